dma_read_block: RTL and testbench

//  Read-side engine of the DMA. Accepts {address, byte count} commands from the descriptor processor into a local command FIFO.

---
 rtl/dma_pkg.sv | 26 ++
 rtl/dma_rd_cmd_fifo.sv | 55 +++++
 rtl/dma_read_block.sv | 147 ++++++++++++++
 tb/tb_dma_read_block.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read engine: FSM states, beat geometry and status word layout.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CMD,
    S_LD_CMD,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DATA,
    S_STATUS
  } rd_state_t;

  localparam int unsigned BYTES_PER_BEAT = 32;
  localparam int unsigned LEN_LSB        = 0;
  localparam int unsigned SEQ_LSB        = 16;
  localparam int unsigned ZERO_BIT       = 24;

  // Round a byte count up to whole beats; 16-bit byte counts need at most 12 bits of beats.
  function automatic logic [11:0] bytes_to_beats(input logic [15:0] bytes);
    logic [16:0] sum;
    sum = {1'b0, bytes} + 17'(BYTES_PER_BEAT - 1);
    return 12'(sum >> $clog2(BYTES_PER_BEAT));
  endfunction

endpackage

// File: rtl/dma_rd_cmd_fifo.sv
// Single-clock, non-show-ahead command FIFO (q valid one cycle after rdreq); writes while full are dropped.
module dma_rd_cmd_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full
);

  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign do_wr = wrreq & ~full;
  assign do_rd = rdreq & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q      <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        q      <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dma_read_block.sv
// DMA read engine: splits queued {bytes, addr} commands into AVMM read bursts,
// forwards returned beats to the data FIFO and posts one status word per command.
module dma_read_block
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CMD_DEPTH = 32,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rd_master_addr_o,
  output logic              rd_master_read_o,
  output logic [10:0]       rd_master_bcount_o,
  input  logic              rd_master_wait_req_i,
  input  logic [DATA_W-1:0] rd_master_data_i,
  input  logic              rd_master_data_valid_i,
  input  logic              dma_rd_fifo_command_req_i,
  input  logic [15:0]       dma_rd_bytes_to_transfer_i,
  input  logic [ADDR_W-1:0] dma_rd_addr_i,
  output logic              dma_rd_fifo_full_o,
  output logic              dma_data_fifo_wr_req_o,
  output logic [DATA_W-1:0] dma_data_fifo_data_o,
  input  logic              dma_data_fifo_almost_full_i,
  output logic              dma_status_fifo_wr_req_o,
  output logic [24:0]       dma_status_fifo_data_o,
  input  logic              dma_status_fifo_almost_full_i
);

  localparam int unsigned CMD_W = 16 + ADDR_W;

  rd_state_t          state;
  rd_state_t          state_nxt;
  logic               cmd_rdreq;
  logic               fifo_empty;
  logic [CMD_W-1:0]   cmd_q;
  logic [ADDR_W-1:0]  addr_r;
  logic [11:0]        rem_beats;
  logic [15:0]        bytes_r;
  logic [10:0]        burst;
  logic [10:0]        beat_cnt;
  logic [7:0]         seq;

  dma_rd_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .aclr  (reset),
    .wrreq (dma_rd_fifo_command_req_i),
    .data  ({dma_rd_bytes_to_transfer_i, dma_rd_addr_i}),
    .rdreq (cmd_rdreq),
    .q     (cmd_q),
    .empty (fifo_empty),
    .full  (dma_rd_fifo_full_o)
  );

  assign rd_master_read_o   = (state == S_ISSUE);
  assign rd_master_addr_o   = addr_r;
  assign rd_master_bcount_o = burst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_rdreq = 1'b0;
    case (state)
      S_IDLE:      if (!fifo_empty) state_nxt = S_RD_CMD;
      S_RD_CMD: begin
        cmd_rdreq = 1'b1;
        state_nxt = S_LD_CMD;
      end
      S_LD_CMD:    state_nxt = S_CHECK;
      S_CHECK: begin
        if (rem_beats == '0)                   state_nxt = S_STATUS;
        else if (!dma_data_fifo_almost_full_i) state_nxt = S_ISSUE;
      end
      S_ISSUE:     if (!rd_master_wait_req_i) state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (rd_master_data_valid_i && (beat_cnt + 11'd1 == burst)) state_nxt = S_CHECK;
      S_STATUS:    if (!dma_status_fifo_almost_full_i) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r                   <= '0;
      rem_beats                <= '0;
      bytes_r                  <= '0;
      burst                    <= '0;
      beat_cnt                 <= '0;
      seq                      <= '0;
      dma_status_fifo_wr_req_o <= 1'b0;
      dma_status_fifo_data_o   <= '0;
    end else begin
      dma_status_fifo_wr_req_o <= 1'b0;
      case (state)
        S_LD_CMD: begin
          addr_r    <= cmd_q[ADDR_W-1:0];
          bytes_r   <= cmd_q[CMD_W-1:ADDR_W];
          rem_beats <= bytes_to_beats(cmd_q[CMD_W-1:ADDR_W]);
        end
        S_CHECK: begin
          if (rem_beats != '0 && !dma_data_fifo_almost_full_i)
            burst <= (rem_beats > 12'(BURST_MAX)) ? 11'(BURST_MAX) : 11'(rem_beats);
        end
        S_ISSUE: begin
          // Advance to the next burst only once the slave has accepted this one.
          if (!rd_master_wait_req_i) begin
            addr_r    <= addr_r + (ADDR_W'(burst) << $clog2(BYTES_PER_BEAT));
            rem_beats <= rem_beats - 12'(burst);
            beat_cnt  <= '0;
          end
        end
        S_WAIT_DATA: begin
          if (rd_master_data_valid_i) beat_cnt <= beat_cnt + 11'd1;
        end
        S_STATUS: begin
          if (!dma_status_fifo_almost_full_i) begin
            dma_status_fifo_wr_req_o                  <= 1'b1;
            dma_status_fifo_data_o[LEN_LSB +: 16]     <= bytes_r;
            dma_status_fifo_data_o[SEQ_LSB +: 8]      <= seq;
            dma_status_fifo_data_o[ZERO_BIT]          <= (bytes_r == '0);
            seq                                       <= seq + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Beats are forwarded regardless of FSM state; data FIFO headroom absorbs them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_data_fifo_wr_req_o <= 1'b0;
      dma_data_fifo_data_o   <= '0;
    end else begin
      dma_data_fifo_wr_req_o <= rd_master_data_valid_i;
      if (rd_master_data_valid_i) dma_data_fifo_data_o <= rd_master_data_i;
    end
  end

endmodule

// File: tb/tb_dma_read_block.sv
// Scoreboard bench for dma_read_block: a command model predicts bursts, beats and status words,
// and a simple AVMM slave returns beats for each accepted burst.
module tb_dma_read_block;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  rd_addr;
  logic         rd_read;
  logic [10:0]  rd_bcount;
  logic         wait_req = 1'b0;
  logic [255:0] rdata = '0;
  logic         rvalid = 1'b0;
  logic         cmd_req;
  logic [15:0]  cmd_bytes;
  logic [31:0]  cmd_addr;
  logic         cmd_full;
  logic         dd_wr;
  logic [255:0] dd_data;
  logic         data_af;
  logic         st_wr;
  logic [24:0]  st_data;
  logic         st_af;

  always #5 clk = ~clk;

  dma_read_block #(
    .DATA_W    (256),
    .ADDR_W    (32),
    .CMD_DEPTH (32),
    .BURST_MAX (16)
  ) dut (
    .clk                           (clk),
    .reset                         (rst),
    .rd_master_addr_o              (rd_addr),
    .rd_master_read_o              (rd_read),
    .rd_master_bcount_o            (rd_bcount),
    .rd_master_wait_req_i          (wait_req),
    .rd_master_data_i              (rdata),
    .rd_master_data_valid_i        (rvalid),
    .dma_rd_fifo_command_req_i     (cmd_req),
    .dma_rd_bytes_to_transfer_i    (cmd_bytes),
    .dma_rd_addr_i                 (cmd_addr),
    .dma_rd_fifo_full_o            (cmd_full),
    .dma_data_fifo_wr_req_o        (dd_wr),
    .dma_data_fifo_data_o          (dd_data),
    .dma_data_fifo_almost_full_i   (data_af),
    .dma_status_fifo_wr_req_o      (st_wr),
    .dma_status_fifo_data_o        (st_data),
    .dma_status_fifo_almost_full_i (st_af)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_bursts = 0;
  int unsigned n_read_cycles = 0;
  int unsigned n_stat = 0;
  int unsigned ws_n = 0;
  int unsigned ws_cnt = 0;
  logic [7:0]  seq_m = '0;

  logic [42:0]  exp_burst [$];
  logic [255:0] exp_data  [$];
  logic [24:0]  exp_stat  [$];
  logic [255:0] ret_q     [$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] beat_data(input logic [31:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic push_model(input logic [31:0] addr, input logic [15:0] bytes);
    int unsigned beats;
    int unsigned b;
    logic [31:0] a;
    beats = (int'(bytes) + 31) / 32;
    a = addr;
    while (beats > 0) begin
      b = (beats > 16) ? 16 : beats;
      exp_burst.push_back({a, 11'(b)});
      a = a + 32'(b * 32);
      beats = beats - b;
    end
    exp_stat.push_back({(bytes == 16'd0), seq_m, bytes});
    seq_m = seq_m + 8'd1;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [15:0] bytes);
    cmd_req   = 1'b1;
    cmd_addr  = addr;
    cmd_bytes = bytes;
    push_model(addr, bytes);
    @(negedge clk);
    cmd_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    while ((exp_burst.size() + exp_data.size() + exp_stat.size() + ret_q.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_complete"}, (n < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bursts(input int unsigned target, input string tag);
    int unsigned n = 0;
    while (n_bursts < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, (n_bursts >= target), 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_ctl"}, {rd_read, rd_addr, rd_bcount, dd_wr, st_wr, st_data, cmd_full}, '0);
    check_eq({tag, "_data"}, dd_data, '0);
  endtask

  // AVMM slave: optional wait states per burst, beats returned back-to-back after acceptance.
  always @(negedge clk) begin
    logic [42:0]  eb;
    logic [255:0] d;
    if (ret_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = ret_q.pop_front();
    end else begin
      rvalid = 1'b0;
    end
    if (rd_read === 1'b1) begin
      n_read_cycles++;
      wait_req = (ws_cnt < ws_n);
      if (wait_req) ws_cnt++;
      if (exp_burst.size() == 0) begin
        check_eq("unexpected_read", rd_read, 0);
      end else begin
        eb = exp_burst[0];
        check_eq("burst_addr", rd_addr, eb[42:11]);
        check_eq("burst_bcount", rd_bcount, eb[10:0]);
        if (!wait_req) begin
          void'(exp_burst.pop_front());
          n_bursts++;
          ws_cnt = 0;
          for (int i = 0; i < int'(eb[10:0]); i++) begin
            d = beat_data(eb[42:11] + 32'(i * 32));
            ret_q.push_back(d);
            exp_data.push_back(d);
          end
        end
      end
    end else begin
      wait_req = 1'b0;
      ws_cnt   = 0;
    end
  end

  always @(negedge clk) begin
    if (dd_wr === 1'b1) begin
      if (exp_data.size() == 0) check_eq("extra_data_write", dd_wr, 0);
      else                      check_eq("data_beat", dd_data, exp_data.pop_front());
    end
    if (st_wr === 1'b1) begin
      n_stat++;
      if (exp_stat.size() == 0) check_eq("extra_status_write", st_wr, 0);
      else                      check_eq("status_word", st_data, exp_stat.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b0;
    int unsigned rc0;
    int unsigned s0;
    rst = 1'b1; cmd_req = 1'b0; cmd_bytes = '0; cmd_addr = '0; data_af = 1'b0; st_af = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // single 2-beat burst, status seq 0
    send_cmd(32'h0000_1000, 16'd64);
    wait_done("t1");

    // two full bursts; data FIFO almost full holds the second one in CHECK
    b0 = n_bursts;
    send_cmd(32'h0000_1000, 16'd1024);
    wait_bursts(b0 + 1, "t5_first_burst");
    data_af = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("t5_no_burst_while_af", n_bursts, b0 + 1);
    check_eq("t5_read_low_while_af", rd_read, 0);
    data_af = 1'b0;
    @(negedge clk);
    check_eq("t5_read_after_release", rd_read, 1);
    wait_done("t2");

    // zero-length command
    send_cmd(32'h0000_4000, 16'd0);
    wait_done("t3");

    // five wait states on one burst
    ws_n = 5;
    rc0 = n_read_cycles;
    b0 = n_bursts;
    send_cmd(32'h0000_3000, 16'd96);
    wait_done("t4");
    check_eq("t4_read_cycles", n_read_cycles - rc0, 6);
    check_eq("t4_burst_count", n_bursts - b0, 1);
    ws_n = 0;

    // partial last beat and 32-bit address wrap between bursts
    send_cmd(32'h0000_5000, 16'd100);
    send_cmd(32'hFFFF_FF00, 16'd544);
    wait_done("wrap");

    // fill the command FIFO while STATUS is stalled; the 33rd write is dropped
    st_af = 1'b1;
    send_cmd(32'h0000_6000, 16'd0);
    repeat (8) @(negedge clk);
    s0 = n_stat;
    for (int i = 0; i < 33; i++) begin
      if (i == 31) check_eq("t6_not_full_at_31", cmd_full, 0);
      if (i == 32) check_eq("t6_full_at_32", cmd_full, 1);
      cmd_req = 1'b1;
      if (i < 32) begin
        cmd_addr  = 32'h0000_2000 + 32'(i * 32);
        cmd_bytes = 16'(i + 1);
        push_model(cmd_addr, cmd_bytes);
      end else begin
        cmd_addr  = 32'hDEAD_0000;
        cmd_bytes = 16'h0777;
      end
      @(negedge clk);
    end
    cmd_req = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t6_status_stalled", n_stat, s0);
    st_af = 1'b0;
    wait_done("t6");
    check_eq("t6_full_cleared", cmd_full, 0);

    // asynchronous reset in the middle of WAIT_DATA
    b0 = n_bursts;
    send_cmd(32'h0000_7000, 16'd512);
    wait_bursts(b0 + 1, "rst_burst_started");
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    exp_burst.delete();
    exp_data.delete();
    exp_stat.delete();
    ret_q.delete();
    seq_m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_cmd(32'h0000_8000, 16'd64);
    wait_done("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
